// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer that sits beside the
// EX-stage ALU. Each operation takes XLEN iterations, one bit per clock:
// a shift-add multiply for MUL/MULHU and a restoring divide for DIVU/REMU.
// While an operation is in flight, stall_ex holds the EX stage. The EX stage
// takes result in the single cycle that done is high.
//
// Timing, with E0 the edge that accepts start:
//   E1..E(XLEN)  RUN iterations; result is registered at E(XLEN)
//   cycle after  DONE: done=1, busy=1, stall_ex=0
//   next edge    back to IDLE
// A divide by zero with DIV0_FAST=1 registers its result at E1 instead.

module muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall_ex,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // op encoding: op[1] selects divide, op[0] selects the "other half"
  // (MULHU high word / REMU remainder).
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  // Multiply: hi_q:lo_q is the 2*XLEN accumulator. lo_q starts as the
  // multiplier, and product bits shift in from the top as it drains.
  // Divide:   hi_q is the partial remainder. lo_q starts as the dividend,
  // and quotient bits shift in from the bottom.
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0] b_q;

  // Combinational next-iteration datapath.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_next;
  logic [XLEN-1:0] mul_lo_next;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_sub;
  logic            div_ge;
  logic [XLEN-1:0] div_hi_next;
  logic [XLEN-1:0] div_lo_next;
  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;
  logic [XLEN-1:0] fin_result;
  logic [XLEN-1:0] div0_result;
  logic            is_div;
  logic            div0_fast_hit;
  logic            last_iter;

  // One multiply or divide step, computed from the current registers.
  always_comb begin
    // NOTE: give every always_comb output a default first, so no path can
    // leave it unassigned and infer a latch.
    mul_hi_next = '0;
    mul_lo_next = '0;
    div_hi_next = '0;
    div_lo_next = '0;

    // Shift-add multiply. The XLEN+1-bit sum keeps the carry, and that carry
    // becomes the new MSB after the right shift.
    mul_sum = {1'b0, hi_q} + {1'b0, b_q};
    if (lo_q[0]) begin
      mul_hi_next = mul_sum[XLEN:1];
      mul_lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      mul_hi_next = {1'b0, hi_q[XLEN-1:1]};
      mul_lo_next = {hi_q[0], lo_q[XLEN-1:1]};
    end

    // Restoring divide. Shift the next dividend bit into the remainder and
    // try the subtract. The shifted remainder is below 2*divisor, so the top
    // bit of the XLEN+1-bit difference is a clean borrow flag.
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_sub = div_sh - {1'b0, b_q};
    div_ge  = ~div_sub[XLEN];
    div_hi_next = div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0];
    div_lo_next = {lo_q[XLEN-2:0], div_ge};
  end

  // Select the active datapath and form the value written to result.
  always_comb begin
    is_div  = op_q[1];
    hi_next = is_div ? div_hi_next : mul_hi_next;
    lo_next = is_div ? div_lo_next : mul_lo_next;

    // MUL and DIVU take the low register; MULHU and REMU take the high one.
    unique case (op_q)
      OP_MUL:   fin_result = lo_next;
      OP_MULHU: fin_result = hi_next;
      OP_DIVU:  fin_result = lo_next;
      OP_REMU:  fin_result = hi_next;
      default:  fin_result = '0;
    endcase

    // On the first RUN edge, lo_q still holds the untouched dividend. That
    // gives REMU-by-zero its rs1 result without waiting.
    div0_result   = op_q[0] ? lo_q : '1;
    div0_fast_hit = DIV0_FAST && is_div && (b_q == '0);
    last_iter     = (cnt_q == LAST_CNT);
  end

  // Hold EX from the request cycle through the last RUN cycle. The DONE
  // cycle is left unstalled so EX can consume the result.
  assign stall_ex = (start && (state_q == S_IDLE) && !flush) || (state_q == S_RUN);

  // Sequencer FSM together with its datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      // Abort from any state. result keeps its value and no done pulse occurs.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            hi_q  <= '0;
            cnt_q <= '0;
            // The divide iterates on the dividend, and the multiply iterates
            // on the multiplier (rs2).
            lo_q  <= op[1] ? rs1 : rs2;
            b_q   <= op[1] ? rs2 : rs1;
            busy    <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          hi_q  <= hi_next;
          lo_q  <= lo_next;
          cnt_q <= cnt_q + CW'(1);
          if (div0_fast_hit) begin
            result  <= div0_result;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else if (last_iter) begin
            result  <= fin_result;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // A start seen in this cycle is deliberately dropped.
          done    <= 1'b0;
          busy    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
